// File: rtl/fft_out_framer.sv
// Output framer for the 4-lane FFT core: ping-pong frame buffer, serial valid/ready output.
// Define FFT_BITREV_EN to read each frame in bit-reversed address order.
module fft_out_framer #(
  parameter int NBITS_out = 10,
  parameter int N         = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NBITS_out-1:0] fftOut0_up,
  input  logic [2*NBITS_out-1:0] fftOut0_down,
  input  logic [2*NBITS_out-1:0] fftOut1_up,
  input  logic [2*NBITS_out-1:0] fftOut1_down,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic [2*NBITS_out-1:0] dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_last,
  output logic                   ovf,
  output logic                   sync_err
);
  localparam int W         = 2*NBITS_out;
  localparam int NUM_LANES = 4;
  localparam int LOGN      = $clog2(N);
  localparam int RW        = LOGN-2;
  localparam int ROWS      = N/4;

  localparam logic [1:0] FREE     = 2'd0;
  localparam logic [1:0] FILLING  = 2'd1;
  localparam logic [1:0] FULL     = 2'd2;
  localparam logic [1:0] DRAINING = 2'd3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] TAIL  = 2'd2;

  logic [NUM_LANES-1:0][W-1:0] laneIn, laneRd;
  logic [1:0][1:0]             bankSt, bankNxt;

  logic [RW-1:0]   wrCnt, wrRow;
  logic            wrPtr, wrBlocked, wrStart, wrAccept, wrLast;

  logic [1:0]      rdState;
  logic [LOGN-1:0] rdCnt, fetchCnt, fetchAddr;
  logic            rdPtr, fetchBank;
  logic [W-1:0]    fetchData;

  assign laneIn = {fftOut1_down, fftOut1_up, fftOut0_down, fftOut0_up};

  // ---------------- write side ----------------
  // FULL and DRAINING both have bit 1 set: the write bank is unavailable
  assign wrBlocked = bankSt[wrPtr][1];
  assign wrStart   = in_valid & (in_sof | (wrCnt != '0));
  assign wrAccept  = wrStart & ~wrBlocked;
  assign wrRow     = in_sof ? '0 : wrCnt;
  assign wrLast    = (wrRow == RW'(ROWS-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrCnt    <= '0;
      wrPtr    <= 1'b0;
      ovf      <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (wrAccept) begin
        wrCnt <= wrLast ? '0 : wrRow + 1'b1;
        if (wrLast) wrPtr <= ~wrPtr;
      end
      if (wrStart & wrBlocked) ovf <= 1'b1;
      if (wrAccept & in_sof & (wrCnt != '0)) sync_err <= 1'b1;
    end
  end

  // Each lane owns one word column of both banks; row = beat index within the frame
  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    logic [W-1:0] ram [2*ROWS];
    always_ff @(posedge clk) begin
      if (wrAccept) ram[{wrPtr, wrRow}] <= laneIn[g];
    end
    assign laneRd[g] = ram[{fetchBank, fetchAddr[LOGN-1:2]}];
  end

  // ---------------- read side ----------------
`ifdef FFT_BITREV_EN
  function automatic logic [LOGN-1:0] bitRev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction
`endif

  // In TAIL the next fetch is sample 0 of the other bank, so a waiting frame starts with no bubble
  always_comb begin
    fetchBank = rdPtr;
    fetchCnt  = rdCnt;
    if (rdState == TAIL) begin
      fetchBank = ~rdPtr;
      fetchCnt  = '0;
    end
`ifdef FFT_BITREV_EN
    fetchAddr = bitRev(fetchCnt);
`else
    fetchAddr = fetchCnt;
`endif
  end

  assign fetchData = laneRd[fetchAddr[1:0]];

  always_comb begin
    bankNxt = bankSt;
    if (wrAccept) bankNxt[wrPtr] = wrLast ? FULL : FILLING;
    case (rdState)
      IDLE:
        if (bankSt[rdPtr] == FULL) bankNxt[rdPtr] = DRAINING;
      TAIL:
        if (dout_ready) begin
          bankNxt[rdPtr] = FREE;
          if (bankSt[~rdPtr] == FULL) bankNxt[~rdPtr] = DRAINING;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bankSt <= {FREE, FREE};
    else      bankSt <= bankNxt;
  end

  // DRAIN loads the output register; TAIL holds sample N-1 until it is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdState    <= IDLE;
      rdPtr      <= 1'b0;
      rdCnt      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      case (rdState)
        IDLE: begin
          if (bankSt[rdPtr] == FULL) begin
            rdState <= DRAIN;
            rdCnt   <= '0;
          end
        end
        DRAIN: begin
          if (!dout_valid || dout_ready) begin
            dout       <= fetchData;
            dout_valid <= 1'b1;
            dout_last  <= (rdCnt == LOGN'(N-1));
            rdCnt      <= rdCnt + 1'b1;
            if (rdCnt == LOGN'(N-1)) rdState <= TAIL;
          end
        end
        TAIL: begin
          if (dout_ready) begin
            rdPtr <= ~rdPtr;
            if (bankSt[~rdPtr] == FULL) begin
              dout       <= fetchData;
              dout_valid <= 1'b1;
              dout_last  <= 1'b0;
              rdCnt      <= LOGN'(1);
              rdState    <= DRAIN;
            end else begin
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              rdState    <= IDLE;
            end
          end
        end
        default: rdState <= IDLE;
      endcase
    end
  end

endmodule
